// File: rtl/ldpc_3gpp_dec_state_sched_pkg.sv
// Shared types for the LDPC node-state scheduler.
// These are the strobe and zc types the decoder uses throughout. They are kept here so the
// scheduler and its delay line build on their own.
//   cMEM_ADDR_W : default state RAM address width
//   hb_zc_t     : zc column count/index type
//   strb_t      : frame/packet strobes {sof, sop, eop, eof}, sof in the MSB
package ldpc_3gpp_dec_state_sched_pkg;

   localparam int unsigned cMEM_ADDR_W = 8;
   localparam int unsigned cZC_W       = 9;

   typedef logic [cZC_W-1:0] hb_zc_t;

   typedef struct packed {
      logic sof;
      logic sop;
      logic eop;
      logic eof;
   } strb_t;

endpackage

// File: rtl/ldpc_3gpp_dec_strb_delay.sv
// Valid + strobe delay line of programmable depth.
// It is used to match a request stream to a datapath latency.
//   iclk, ireset_n : clock, asynchronous active-low clear (empties the line)
//   iclkena        : clock enable, low holds the line
//   ival, istrb    : input valid and strobes
//   oval, ostrb    : the same, pDEPTH enabled cycles later
module ldpc_3gpp_dec_strb_delay
   import ldpc_3gpp_dec_state_sched_pkg::*;
#(
   parameter int unsigned pDEPTH = 1
) (
   input  logic  iclk,
   input  logic  ireset_n,
   input  logic  iclkena,
   input  logic  ival,
   input  strb_t istrb,
   output logic  oval,
   output strb_t ostrb
);

   logic  val_q  [pDEPTH];
   strb_t strb_q [pDEPTH];

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         for (int i = 0; i < pDEPTH; i++) begin
            val_q[i]  <= 1'b0;
            strb_q[i] <= '0;
         end
      end else if (iclkena) begin
         val_q[0]  <= ival;
         strb_q[0] <= istrb;
         for (int i = 1; i < pDEPTH; i++) begin
            val_q[i]  <= val_q[i-1];
            strb_q[i] <= strb_q[i-1];
         end
      end
   end

   assign oval  = val_q[pDEPTH-1];
   assign ostrb = strb_q[pDEPTH-1];

endmodule

// File: rtl/ldpc_3gpp_dec_state_sched.sv
// Iteration scheduler for the LDPC node-state memory.
// Each pass walks the state RAM zc-column by row-group and emits a read stream. A delayed copy of
// that stream forms the write stream. The pass repeats initer times, and a drain gap between
// passes keeps a read from overtaking the previous pass's write.
//   iclk, ireset_n, iclkena       : clock, async active-low reset, clock enable
//   istart                        : start request (IDLE only)
//   iused_zc, iused_row, initer   : pass geometry and pass count, latched at start
//   oread, orstart, orval, orstrb : read request, first read of pass, valid, strobes
//   owrite, owstrb                : write request and strobes
//   obusy, odone, oiter           : decode in progress, completion pulse, current pass index
module ldpc_3gpp_dec_state_sched
   import ldpc_3gpp_dec_state_sched_pkg::*;
#(
   parameter int unsigned pADDR_W   = cMEM_ADDR_W,
   parameter int unsigned pDP_DELAY = 2,
   parameter int unsigned pITER_W   = 8
) (
   input  logic               iclk,
   input  logic               ireset_n,
   input  logic               iclkena,
   input  logic               istart,
   input  hb_zc_t             iused_zc,
   input  logic [pADDR_W-1:0] iused_row,
   input  logic [pITER_W-1:0] initer,
   output logic               oread,
   output logic               orstart,
   output logic               orval,
   output strb_t              orstrb,
   output logic               owrite,
   output strb_t              owstrb,
   output logic               obusy,
   output logic               odone,
   output logic [pITER_W-1:0] oiter
);

   localparam int unsigned cDRAIN   = pDP_DELAY + 6;
   localparam int unsigned cWR_LAT  = pDP_DELAY + 4;
   localparam int unsigned cDRAIN_W = $clog2(cDRAIN + 1);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   hb_zc_t               zc_q, zc_d, used_zc_q, used_zc_d;
   logic [pADDR_W-1:0]   row_q, row_d, used_row_q, used_row_d;
   logic [pITER_W-1:0]   iter_q, iter_d, niter_q, niter_d;
   logic [cDRAIN_W-1:0]  drain_q, drain_d;

   logic  rd;
   strb_t rd_strb;
   logic  cfg_zero, last_row, last_zc, last_iter;

   assign cfg_zero  = (used_zc_q == '0) || (used_row_q == '0) || (niter_q == '0);
   assign last_row  = (row_q == used_row_q - pADDR_W'(1));
   assign last_zc   = (zc_q == used_zc_q - hb_zc_t'(1));
   assign last_iter = (iter_q == niter_q - pITER_W'(1));

   always_comb begin
      state_d    = state_q;
      zc_d       = zc_q;
      row_d      = row_q;
      used_zc_d  = used_zc_q;
      used_row_d = used_row_q;
      iter_d     = iter_q;
      niter_d    = niter_q;
      drain_d    = drain_q;
      rd         = 1'b0;
      rd_strb    = '0;
      odone      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (istart) begin
               used_zc_d  = iused_zc;
               used_row_d = iused_row;
               niter_d    = initer;
               iter_d     = '0;
               zc_d       = '0;
               row_d      = '0;
               state_d    = StRead;
            end
         end
         StRead: begin
            // A zero-sized configuration finishes without touching the RAM.
            if (cfg_zero) begin
               state_d = StDone;
            end else begin
               rd          = 1'b1;
               rd_strb.sop = (row_q == '0);
               rd_strb.eop = last_row;
               rd_strb.sof = rd_strb.sop && (zc_q == '0);
               rd_strb.eof = last_row && last_zc;
               if (last_row) begin
                  row_d = '0;
                  if (last_zc) begin
                     zc_d    = '0;
                     drain_d = cDRAIN_W'(1);  // eof beat is count 0
                     state_d = StDrain;
                  end else begin
                     zc_d = zc_q + hb_zc_t'(1);
                  end
               end else begin
                  row_d = row_q + pADDR_W'(1);
               end
            end
         end
         StDrain: begin
            drain_d = drain_q + cDRAIN_W'(1);
            // The final pass reports done at eof+cDRAIN. A following pass restarts one cycle
            // later, so its sof read reaches the RAM after the last write of this pass lands.
            if (last_iter && (drain_q == cDRAIN_W'(cDRAIN - 1))) begin
               state_d = StDone;
            end else if (!last_iter && (drain_q == cDRAIN_W'(cDRAIN))) begin
               iter_d  = iter_q + pITER_W'(1);
               state_d = StRead;
            end
         end
         StDone: begin
            odone   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state_q    <= StIdle;
         zc_q       <= '0;
         row_q      <= '0;
         used_zc_q  <= '0;
         used_row_q <= '0;
         iter_q     <= '0;
         niter_q    <= '0;
         drain_q    <= '0;
      end else if (iclkena) begin
         state_q    <= state_d;
         zc_q       <= zc_d;
         row_q      <= row_d;
         used_zc_q  <= used_zc_d;
         used_row_q <= used_row_d;
         iter_q     <= iter_d;
         niter_q    <= niter_d;
         drain_q    <= drain_d;
      end
   end

   assign oread   = rd;
   assign orval   = rd;
   assign orstrb  = rd_strb;
   assign orstart = rd && rd_strb.sof;
   assign obusy   = (state_q != StIdle);
   assign oiter   = iter_q;

   ldpc_3gpp_dec_strb_delay #(
      .pDEPTH (cWR_LAT)
   ) u_wr_delay (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (iclkena),
      .ival     (rd),
      .istrb    (rd_strb),
      .oval     (owrite),
      .ostrb    (owstrb)
   );

endmodule

// File: tb/tb_ldpc_3gpp_dec_state_sched.sv
module tb_ldpc_3gpp_dec_state_sched;
   import ldpc_3gpp_dec_state_sched_pkg::*;

   localparam int DP   = 2;
   localparam int WL   = DP + 4;
   localparam int MAXL = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iclkena = 1'b0;
   logic       istart = 1'b0;
   hb_zc_t     iused_zc = '0;
   logic [7:0] iused_row = '0;
   logic [7:0] initer = '0;
   logic       oread, orstart, orval, owrite, obusy, odone;
   strb_t      orstrb, owstrb;
   logic [7:0] oiter;

   ldpc_3gpp_dec_state_sched #(
      .pADDR_W   (8),
      .pDP_DELAY (DP),
      .pITER_W   (8)
   ) dut (
      .iclk      (clk),
      .ireset_n  (rst_n),
      .iclkena   (iclkena),
      .istart    (istart),
      .iused_zc  (iused_zc),
      .iused_row (iused_row),
      .initer    (initer),
      .oread     (oread),
      .orstart   (orstart),
      .orval     (orval),
      .orstrb    (orstrb),
      .owrite    (owrite),
      .owstrb    (owstrb),
      .obusy     (obusy),
      .odone     (odone),
      .oiter     (oiter)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;

   // Expected timeline, indexed by enabled cycles since the istart cycle.
   bit         exp_rd   [MAXL];
   logic [3:0] exp_rs   [MAXL];
   bit         exp_wr   [MAXL];
   logic [3:0] exp_ws   [MAXL];
   bit         exp_busy [MAXL];
   bit         exp_done [MAXL];
   int         exp_iter [MAXL];

   int idx;
   int n_rd, n_rs, done_at, first_wr;
   int rs_at [4];
   int rd_pass, rd_addr, wr_pass, wr_addr;
   int wr_land [64];
   int wr_pass_of [64];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s at idx %0d: got %0d expected %0d", name, idx, got, exp);
      end
   endtask

   // Pass structure from the rules: reads from cycle 1, eof at T, next sof at T+DP+7,
   // done at T+DP+6 of the last pass, writes are reads shifted by WL.
   task automatic build_model(input int z, input int r, input int n, output int len);
      int t, tl, dc, sofc;
      for (int c = 0; c < MAXL; c++) begin
         exp_rd[c] = 0; exp_rs[c] = '0; exp_wr[c] = 0; exp_ws[c] = '0;
         exp_busy[c] = 0; exp_done[c] = 0; exp_iter[c] = 0;
      end
      dc = 2;
      if (z != 0 && r != 0 && n != 0) begin
         t = 1;
         for (int it = 0; it < n; it++) begin
            sofc = t;
            for (int zz = 0; zz < z; zz++) begin
               for (int rr = 0; rr < r; rr++) begin
                  exp_rd[t] = 1;
                  exp_rs[t] = {zz == 0 && rr == 0, rr == 0, rr == r - 1,
                               zz == z - 1 && rr == r - 1};
                  t++;
               end
            end
            tl = t - 1;
            for (int c = sofc; c < MAXL; c++) exp_iter[c] = it;
            if (it == n - 1) dc = tl + DP + 6;
            else t = tl + DP + 7;
         end
      end
      for (int c = 1; c <= dc; c++) exp_busy[c] = 1;
      exp_done[dc] = 1;
      for (int c = 0; c + WL < MAXL; c++) begin
         exp_wr[c + WL] = exp_rd[c];
         exp_ws[c + WL] = exp_rs[c];
      end
      len = dc + 2;
   endtask

   task automatic check_cycle(input int i);
      chk("oread", 32'(oread), 32'(exp_rd[i]));
      chk("orval", 32'(orval), 32'(exp_rd[i]));
      chk("orstrb", 32'(orstrb), 32'(exp_rs[i]));
      chk("orstart", 32'(orstart), 32'(exp_rd[i] & exp_rs[i][3]));
      chk("owrite", 32'(owrite), 32'(exp_wr[i]));
      chk("owstrb", 32'(owstrb), 32'(exp_ws[i]));
      chk("obusy", 32'(obusy), 32'(exp_busy[i]));
      chk("odone", 32'(odone), 32'(exp_done[i]));
      if (i >= 1) chk("oiter", 32'(oiter), 32'(exp_iter[i]));
      if (iclkena) begin
         if (oread) begin
            n_rd++;
            if (orstart && n_rs < 4) begin rs_at[n_rs] = i; n_rs++; end
            if (orstrb.sof) begin rd_pass++; rd_addr = 0; end
            if (rd_pass > 0 && rd_addr < 64)
               chk("raw_hazard", 32'(wr_pass_of[rd_addr] == rd_pass - 1 &&
                                     wr_land[rd_addr] < i + 2), 32'(1));
            rd_addr++;
         end
         if (owrite) begin
            if (first_wr < 0) first_wr = i;
            if (owstrb.sof) begin wr_pass++; wr_addr = 0; end
            if (wr_addr < 64) begin
               wr_land[wr_addr] = i + 3;
               wr_pass_of[wr_addr] = wr_pass;
            end
            wr_addr++;
         end
         if (odone) done_at = i;
      end
   endtask

   task automatic run_cfg(input int z, input int r, input int n, input bit rnd,
                          input int pulse_at, input int rst_at);
      int len, guard;
      bit en, hit_rst;
      build_model(z, r, n, len);
      n_rd = 0; n_rs = 0; done_at = -1; first_wr = -1;
      for (int k = 0; k < 4; k++) rs_at[k] = -1;
      rd_pass = -1; rd_addr = 0; wr_pass = -1; wr_addr = 0;
      for (int k = 0; k < 64; k++) begin wr_land[k] = 0; wr_pass_of[k] = -1; end
      @(posedge clk);
      #1;
      iused_zc = hb_zc_t'(z); iused_row = 8'(r); initer = 8'(n);
      istart = 1'b1; iclkena = 1'b1; idx = 0; guard = 0; hit_rst = 0;
      forever begin
         @(negedge clk);
         check_cycle(idx);
         if (idx >= len) break;
         en = iclkena;
         @(posedge clk);
         if (en) idx++;
         #1;
         istart = 1'b0;
         iclkena = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (en && idx == pulse_at) begin
            istart = 1'b1; iused_zc = 1; iused_row = 1; initer = 5;
         end
         if (idx == rst_at) begin hit_rst = 1; break; end
         guard++;
         if (guard > 2000) begin
            nerr++;
            $display("FAIL timeout: run did not reach idx %0d, at %0d", len, idx);
            break;
         end
      end
      if (hit_rst) begin
         rst_n = 1'b0; iclkena = 1'b1;
         @(negedge clk);
         chk("rst_oread", 32'(oread), 0);
         chk("rst_owrite", 32'(owrite), 0);
         chk("rst_obusy", 32'(obusy), 0);
         chk("rst_odone", 32'(odone), 0);
         chk("rst_orstart", 32'(orstart), 0);
         chk("rst_oiter", 32'(oiter), 0);
         chk("rst_strbs", 32'({orstrb, owstrb}), 0);
         @(posedge clk);
         #1 rst_n = 1'b1;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_owrite", 32'(owrite), 0);
            chk("post_rst_oread", 32'(oread), 0);
            chk("post_rst_obusy", 32'(obusy), 0);
         end
      end
      istart = 1'b0;
   endtask

   initial begin
      #12;
      chk("reset_oread", 32'(oread), 0);
      chk("reset_owrite", 32'(owrite), 0);
      chk("reset_obusy", 32'(obusy), 0);
      chk("reset_odone", 32'(odone), 0);
      chk("reset_oiter", 32'(oiter), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Z=3, R=2, one pass: reads 1..6, writes 7..12, done 14.
      run_cfg(3, 2, 1, 0, -1, -1);
      chk("model_sof_beat", 32'(exp_rs[1]), 32'(4'b1100));
      chk("model_eof_beat", 32'(exp_rs[6]), 32'(4'b0011));
      chk("model_done14", 32'(exp_done[14]), 1);
      chk("t1_done_at", 32'(done_at), 14);
      chk("t1_reads", 32'(n_rd), 6);
      chk("t1_first_wr", 32'(first_wr), 7);

      // Three passes: sof at 1, 15, 29, done 42.
      run_cfg(3, 2, 3, 0, -1, -1);
      chk("t2_rs1", 32'(rs_at[1]), 15);
      chk("t2_rs2", 32'(rs_at[2]), 29);
      chk("t2_done_at", 32'(done_at), 42);

      // Same with a random clock enable; spacing in enabled cycles unchanged.
      run_cfg(3, 2, 3, 1, -1, -1);
      chk("t3_done_at", 32'(done_at), 42);
      chk("t3_reads", 32'(n_rd), 18);

      // Single-beat passes, 8 idle cycles between reads.
      run_cfg(1, 1, 2, 0, -1, -1);
      chk("t4_rs_gap", 32'(rs_at[1] - rs_at[0]), 9);
      chk("t4_done_at", 32'(done_at), 18);

      // Zero rows: no traffic, done two cycles after istart.
      run_cfg(3, 0, 1, 0, -1, -1);
      chk("t5_done_at", 32'(done_at), 2);
      chk("t5_reads", 32'(n_rd), 0);

      // istart with a different config during READ is ignored.
      run_cfg(3, 2, 1, 0, 3, -1);
      chk("t6_done_at", 32'(done_at), 14);
      chk("t6_reads", 32'(n_rd), 6);

      // Reset during the drain of pass 0, then a clean restart.
      run_cfg(3, 2, 2, 0, -1, 8);
      run_cfg(3, 2, 1, 0, -1, -1);
      chk("t7_done_at", 32'(done_at), 14);
      chk("t7_first_wr", 32'(first_wr), 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
